// File: rtl/ysyx_23060278_seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide, behind an IDLE/BUSY/DONE request/response handshake.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE and out_valid only in DONE, so at most one operation is in
// flight and result/flags hold steady while out_valid waits for out_ready.
module ysyx_23060278_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zf,
  output logic             nf,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         sel_q;      // {divide, high half} of the iterative op
  logic [2*WIDTH-1:0] acc;        // {hi, lo}: product, or {remainder, quotient}
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt;

  logic               is_iter, is_sub, last_step;
  logic [WIDTH-1:0]   b_eff, sum, res_single, res_iter;
  logic               ovf_single;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  assign is_iter   = (op[3:2] == 2'b10);
  assign last_step = (cnt == LAST_STEP);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  // Single-cycle datapath, evaluated directly from the incoming operands
  always_comb begin
    is_sub     = (op == 4'b0001);
    b_eff      = is_sub ? ~b : b;
    sum        = a + b_eff + WIDTH'(is_sub);
    res_single = '0;
    ovf_single = 1'b0;
    case (op)
      4'b0000, 4'b0001: begin
        res_single = sum;
        ovf_single = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: res_single = a & b;
      4'b0011: res_single = a | b;
      4'b0100: res_single = a ^ b;
      4'b0101: res_single = WIDTH'($signed(a) < $signed(b));
      4'b0110: res_single = WIDTH'(a < b);
      default: res_single = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring-subtract divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (sel_q[1]) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    res_iter = sel_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = is_iter ? BUSY : DONE;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      zf       <= 1'b1;
      nf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= op[1:0];
            cnt   <= '0;
            if (is_iter) begin
              acc <= op[1] ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            end else begin
              result   <= res_single;
              overflow <= ovf_single;
              zf       <= (res_single == '0);
              nf       <= res_single[WIDTH-1];
            end
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            result   <= res_iter;
            overflow <= 1'b0;
            zf       <= (res_iter == '0);
            nf       <= res_iter[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
